// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the run-time LUT configuration controller:
// the controller state encoding and the fixed LUT geometry.
package lut_cfg_pkg;

  localparam int LUT_BITS = 32;  // truth-table bits per 5-input LUT
  localparam int LUT_IN_W = 5;   // address width of one LUT

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/lut5_cfg_ctrl_if.sv
// Configuration port of the LUT bank: load control, beat handshake and
// status pulses. The controller is the slave; whoever streams tables is the master.
interface lut5_cfg_ctrl_if #(
  parameter int CFG_W = 8
);

  logic             start;
  logic             abort;
  logic             cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, cfg_valid, cfg_data,
    input  cfg_ready, busy, done, err
  );

  modport slave (
    input  start, abort, cfg_valid, cfg_data,
    output cfg_ready, busy, done, err
  );

endinterface

// File: rtl/lut5_rt.sv
// One run-time configurable 5-input LUT: a 32-bit active truth table that is
// replaced wholesale when we is high, plus a registered lookup of that table.
module lut5_rt
  import lut_cfg_pkg::*;
#(
  parameter logic [LUT_BITS-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [LUT_BITS-1:0] tbl_in,
  input  logic [LUT_IN_W-1:0] addr,
  output logic                o
);

  logic [LUT_BITS-1:0] tbl_q, tbl_d;
  logic                o_q, o_d;

  // Next table and lookup; the lookup reads the current table, so a table
  // written on this edge only reaches o one edge later.
  always_comb begin
    tbl_d = we ? tbl_in : tbl_q;
    o_d   = tbl_q[addr];
  end

  // Table and output registers.
  // NOTE: storage arrays are reset here too, because the active table must
  // return to a known truth table whenever rst_n drops, even mid-load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= INIT_VAL;
      o_q   <= 1'b0;
    end else begin
      tbl_q <= tbl_d;
      o_q   <= o_d;
    end
  end

  assign o = o_q;

endmodule

// File: rtl/lut5_cfg_ctrl.sv
// Run-time configuration controller for a bank of NUM_LUT 5-input LUTs.
// Tables stream in word-serially into a shadow store; after the last beat the
// whole bank commits in a single cycle, so lookups never see a half-loaded bank.
module lut5_cfg_ctrl
  import lut_cfg_pkg::*;
#(
  parameter int          NUM_LUT  = 4,
  parameter int          CFG_W    = 8,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lut5_cfg_ctrl_if.slave               cfg,
  input  logic [LUT_IN_W*NUM_LUT-1:0]  lut_in,
  output logic [NUM_LUT-1:0]           lut_out
);

  localparam int BEATS  = NUM_LUT * LUT_BITS / CFG_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SHAD_W = NUM_LUT * LUT_BITS;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [SHAD_W-1:0]   shadow_q, shadow_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                xfer;
  logic                commit;

  assign xfer   = cfg.cfg_valid & cfg_ready_q;
  assign commit = (state_q == COMMIT);

  // Next-state, beat counting and shadow writes. Abort outranks a beat in the
  // same cycle; start is only looked at in IDLE, so start-while-busy is ignored.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    shadow_d   = shadow_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg.start) begin
          state_d    = LOAD;
          beat_cnt_d = '0;
        end
      end
      LOAD: begin
        if (cfg.abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (xfer) begin
          shadow_d[int'(beat_cnt_q)*CFG_W +: CFG_W] = cfg.cfg_data;
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = COMMIT;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Handshake/status flags are registered copies of the upcoming state.
    cfg_ready_d = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
  end

  // Controller registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      shadow_q    <= {NUM_LUT{INIT_VAL}};
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      shadow_q    <= shadow_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg.busy      = busy_q;
  assign cfg.done      = done_q;
  assign cfg.err       = err_q;

  // LUT bank: every table loads from its shadow slice in the COMMIT cycle.
  for (genvar k = 0; k < NUM_LUT; k++) begin : g_lut
    lut5_rt #(
      .INIT_VAL (INIT_VAL)
    ) u_lut (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (commit),
      .tbl_in (shadow_q[k*LUT_BITS +: LUT_BITS]),
      .addr   (lut_in[k*LUT_IN_W +: LUT_IN_W]),
      .o      (lut_out[k])
    );
  end

endmodule
